// File: rtl/shift_unit_seq_if.sv
// -----------------------------------------------------------------------------
// shift_unit_seq_if
//
// Purpose: bundles the request and result handshakes of shift_unit_seq.
//
// Signals (WIDTH-bit operand, SHAMT_W = $clog2(WIDTH)):
//   in_valid   request valid                        (master -> slave)
//   in_ready   unit can accept a request            (slave  -> master)
//   in_data    operand, WIDTH bits                  (master -> slave)
//   in_shamt   shift amount, SHAMT_W bits           (master -> slave)
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR       (master -> slave)
//   out_valid  result valid                         (slave  -> master)
//   out_ready  consumer accepts the result          (master -> slave)
//   out_data   result, WIDTH bits                   (slave  -> master)
//   busy       operation in flight or result held   (slave  -> master)
//
// Modports: master = issue/writeback side, slave = the shift unit.
// -----------------------------------------------------------------------------
interface shift_unit_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//
// Purpose: multi-cycle shift/rotate unit. One shift-amount bit is resolved per
// clock (MSB first), so each cycle applies either a shift by 2^k or nothing.
// Latency from the accept edge to out_valid is always SHAMT_W cycles.
//
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       shift_unit_seq_if.slave (request/result handshakes, busy)
//
// Parameters:
//   WIDTH     operand width, power of two, >= 4
//
// Configuration macro:
//   SHIFT_UNIT_ROTATE_EN  when defined, op 11 rotates right; when undefined the
//                         rotate datapath is absent and op 11 behaves as SRL.
// -----------------------------------------------------------------------------
module shift_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  shift_unit_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] K_TOP = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] K_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [SHAMT_W-1:0] k_q,     k_d;
  op_e                op_q,    op_d;

  // One stage of the shifter: shift val by 2^k according to op.
  // SRA replicates val[WIDTH-1]; since that bit never changes across stages
  // the working register itself carries the sign.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0]   val,
    input op_e                op,
    input logic [SHAMT_W-1:0] k
  );
    int unsigned amt;
    logic [WIDTH-1:0] res;
    amt = 32'd1 << k;
    res = val;
    case (op)
      OP_SLL: res = val << amt;
      OP_SRA: res = WIDTH'($signed(val) >>> amt);
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_SRL: res = val >> amt;
      OP_ROR: res = (val >> amt) | (val << (WIDTH - amt));
`else
      // Without the rotate datapath op 11 shares the logical-right path.
      OP_SRL, OP_ROR: res = val >> amt;
`endif
      default: res = val;
    endcase
    return res;
  endfunction

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      k_q     <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      k_q     <= k_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    k_d     = k_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          shamt_d = bus.in_shamt;
          op_d    = op_e'(bus.in_op);
          k_d     = K_TOP;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shamt_q[k_q]) begin
          acc_d = stage_shift(acc_q, op_q, k_q);
        end
        // Every stage is visited regardless of shamt, keeping latency fixed.
        if (k_q == '0) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q - K_ONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs come straight from registers, never from in_* or out_ready.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_seq
//
// Directed bench for shift_unit_seq: a 32-bit and an 8-bit instance share the
// clock and reset. Expected results are queued when a request is issued and
// popped when the unit presents its result.
// -----------------------------------------------------------------------------
module tb_shift_unit_seq;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  shift_unit_seq_if #(.WIDTH(32)) bus32 ();
  shift_unit_seq_if #(.WIDTH(8))  bus8 ();

  shift_unit_seq #(.WIDTH(32)) dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus32.slave)
  );

  shift_unit_seq #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ideal whole-word reference of each operation.
  function automatic logic [31:0] ref32(input logic [1:0] op,
                                        input logic [31:0] x, input int n);
    case (op)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return 32'($signed(x) >>> n);
`ifdef SHIFT_UNIT_ROTATE_EN
      default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
`else
      default: return x >> n;
`endif
    endcase
  endfunction

  // Called #1 after a rising edge; leaves the bench #1 after the accept edge.
  task automatic issue32(input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] shamt, input logic [31:0] exp);
    check("issue_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    bus32.in_op    = op;
    bus32.in_data  = data;
    bus32.in_shamt = shamt;
    bus32.in_valid = 1'b1;
    @(posedge clock); #1;
    bus32.in_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  // Waits (bounded) for out_valid, checks latency and data against the queue.
  task automatic collect32(input string tag);
    int lat;
    logic [31:0] e;
    lat = 0;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd5);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check(tag, bus32.out_data, e);
  endtask

  task automatic consume32(input string tag);
    bus32.out_ready = 1'b1;
    @(posedge clock); #1;
    bus32.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, bus32.in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'd0, bus32.out_valid}, 32'd0);
  endtask

  task automatic run32(input string tag, input logic [1:0] op,
                       input logic [31:0] data, input logic [4:0] shamt,
                       input logic [31:0] exp);
    issue32(op, data, shamt, exp);
    collect32(tag);
    consume32(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] rd;
    logic [1:0]  rop;
    logic [4:0]  rsh;
    int          lat8;
    logic [7:0]  e8;

    reset_n         = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.in_data   = '0;
    bus32.in_shamt  = '0;
    bus32.in_op     = '0;
    bus32.out_ready = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.in_shamt   = '0;
    bus8.in_op      = '0;
    bus8.out_ready  = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("rst_out_data",  bus32.out_data, 32'd0);
    check("rst_busy",      {31'd0, bus32.busy}, 32'd0);
    check("rst_in_ready",  {31'd0, bus32.in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors
    run32("sra_min_31",  2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run32("srl_msb_31",  2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run32("sll_f_4",     2'b00, 32'h0000_000F, 5'd4,  32'h0000_00F0);
    run32("sra_pos_4",   2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF);
    for (int op = 0; op < 4; op++) begin
      run32($sformatf("shamt0_op%0d", op), 2'(op), 32'h1234_5678, 5'd0,
            32'h1234_5678);
    end

`ifdef SHIFT_UNIT_ROTATE_EN
    run32("ror_1_1",     2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);
    run32("ror_f00f_4",  2'b11, 32'hF000_000F, 5'd4, 32'hFF00_0000);
`else
    run32("ror_1_1",     2'b11, 32'h0000_0001, 5'd1, 32'h0000_0000);
    run32("ror_f00f_4",  2'b11, 32'hF000_000F, 5'd4, 32'h0F00_0000);
`endif

    // Backpressure: result held, new request ignored
    issue32(2'b01, 32'hA5A5_A5A5, 5'd3, ref32(2'b01, 32'hA5A5_A5A5, 3));
    collect32("bp_result");
    held = bus32.out_data;
    for (int i = 0; i < 10; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_data  = 32'hDEAD_BEEF;
      bus32.in_op    = 2'b00;
      bus32.in_shamt = 5'd1;
      @(posedge clock); #1;
      check("bp_data_stable", bus32.out_data, held);
      check("bp_in_ready",    {31'd0, bus32.in_ready}, 32'd0);
      check("bp_out_valid",   {31'd0, bus32.out_valid}, 32'd1);
    end
    bus32.in_valid = 1'b0;
    consume32("bp_release");
    check("bp_no_accept_busy", {31'd0, bus32.busy}, 32'd0);

    // Random operations against the whole-word reference
    for (int i = 0; i < 8; i++) begin
      rd  = $urandom;
      rop = 2'($urandom_range(0, 3));
      rsh = 5'($urandom_range(0, 31));
      run32($sformatf("rand%0d", i), rop, rd, rsh, ref32(rop, rd, int'(rsh)));
    end

    // Reset during the third SHIFT cycle
    bus32.in_op    = 2'b00;
    bus32.in_data  = 32'h1234_5678;
    bus32.in_shamt = 5'd5;
    bus32.in_valid = 1'b1;
    @(posedge clock); #1;
    bus32.in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid_busy", {31'd0, bus32.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("mid_rst_busy",      {31'd0, bus32.busy}, 32'd0);
    check("mid_rst_out_data",  bus32.out_data, 32'd0);
    #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_in_ready", {31'd0, bus32.in_ready}, 32'd1);
    check("post_rst_busy",     {31'd0, bus32.busy}, 32'd0);
    run32("post_rst_sra", 2'b10, 32'hFFFF_FF00, 5'd8, 32'hFFFF_FFFF);

    // 8-bit instance
    check("w8_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    bus8.in_op    = 2'b10;
    bus8.in_data  = 8'h90;
    bus8.in_shamt = 3'd3;
    bus8.in_valid = 1'b1;
    @(posedge clock); #1;
    bus8.in_valid = 1'b0;
    exp8_q.push_back(8'hF2);
    lat8 = 0;
    while (!bus8.out_valid && lat8 < 20) begin
      @(posedge clock); #1;
      lat8++;
    end
    check("w8_latency", lat8, 32'd3);
    e8 = (exp8_q.size() > 0) ? exp8_q.pop_front() : 8'hxx;
    check("w8_sra_90_3", {24'd0, bus8.out_data}, {24'd0, e8});
    bus8.out_ready = 1'b1;
    @(posedge clock); #1;
    bus8.out_ready = 1'b0;
    check("w8_in_ready_after", {31'd0, bus8.in_ready}, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Multi-cycle, parametrised shift/rotate unit for the ALU datapath. It is the successor to the fixed 32-bit combinational arithmetic-right shifter. It supports logical left, logical right, arithmetic right and (optionally) rotate right on a WIDTH-bit operand. The unit resolves one shift-amount bit per clock to keep the critical path at a single 2:1 mux stage, and it connects to the issue and writeback logic through valid/ready handshakes.

## Interface
- WIDTH, 32: operand width. Must be a power of two and ≥ 4.
- SHAMT_W, $clog2(WIDTH): localparam, width of the shift amount. Not overridable.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: works through stages k = SHAMT_W-1 down to 0.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid at a clock edge:
  - Capture in_data into the working register acc.
  - Capture in_shamt into shamt_r and in_op into op_r.
  - Set k=SHAMT_W-1.
- SHIFT, at each edge:
  - If shamt_r[k]=1, acc is shifted by 2^k according to op_r. Otherwise acc holds.
  - If k≠0, k decrements. If k=0, the state moves to DONE.
- Per-stage fill rules:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: acc[WIDTH-1] is replicated. The sign bit is invariant across stages, so no separate sign register is needed.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- DONE → IDLE on out_ready. out_data equals acc and is held stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside IDLE. No request is queued, and in_data changes outside IDLE have no effect.
- shamt_r=0: no stage shifts. The result equals the operand, with full latency. Latency is fixed and never data-dependent.
- Arithmetic reference: the result equals the ideal shift of the WIDTH-bit operand by shamt mod WIDTH. SRA(x, n) = floor(x / 2^n) for signed x.
- Reset asserted in any state:
  - State goes to IDLE immediately.
  - acc, out_data, out_valid and busy go to 0.
  - Any in-flight operation is discarded.
- Reset values: out_valid=0, out_data=0, busy=0, in_ready=1. in_valid is not sampled while reset_n=0.

## Timing
- Accept edge E0, then stage edges E1..E_SHAMT_W. out_valid rises after E_SHAMT_W, i.e. SHAMT_W cycles after acceptance (5 for WIDTH=32).
- The result is consumed on the first edge with out_valid&out_ready. in_ready rises in the following cycle.
- Back-to-back throughput with out_ready held high: one operation per SHAMT_W+2 cycles (7 for WIDTH=32).
- All outputs are registered or decoded directly from the state register. There is no combinational path from in_* or out_ready to any output.

## Configuration
- SHIFT_UNIT_ROTATE_EN defined: op 11 performs rotate right as described above.
- SHIFT_UNIT_ROTATE_EN undefined:
  - The rotate datapath is absent.
  - op 11 executes exactly as SRL (01) with identical latency.
  - No error is signalled.

## Test plan
- SRA, in_data=0x80000000, shamt=31, WIDTH=32 → out_data=0xFFFFFFFF. out_valid high exactly 5 cycles after the accept edge.
- SRL 0x80000000 shamt=31 → 0x00000001. SLL 0x0000000F shamt=4 → 0x000000F0. SRA 0x7FFFFFF0 shamt=4 → 0x07FFFFFF. Any op with shamt=0 on 0x12345678 → 0x12345678 after 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_data stays constant and in_ready stays 0.
  - A new in_valid with 0xDEADBEEF is not accepted.
  - After out_ready=1, in_ready rises in the next cycle.
- ROR 0x00000001 shamt=1 → 0x80000000 with SHIFT_UNIT_ROTATE_EN defined, and 0x00000000 without it. ROR 0xF000000F shamt=4 → 0xFF000000 with the macro defined.
- Drop reset_n to 0 during the 3rd SHIFT cycle:
  - out_valid, busy and out_data go to 0 immediately, with no clock edge needed.
  - After release, in_ready=1.
  - The next request, SRA 0xFFFFFF00 shamt=8, returns 0xFFFFFFFF.
- WIDTH=8 instance: SRA 0x90 shamt=3 → 0xF2, with out_valid 3 cycles after accept.
